// File: rtl/sar_adc_sequencer.sv
// Successive-approximation conversion sequencer: scans masked channels in ascending
// order, runs a WIDTH-step binary search per channel, and hands results out over valid/ready.
module sar_adc_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              cmp_in,
  output logic [WIDTH-1:0]  dac_code,
  output logic [CH_W-1:0]   ch_sel,
  output logic              busy,
  output logic              result_valid,
  output logic [WIDTH-1:0]  result_data,
  output logic [CH_W-1:0]   result_ch,
  input  logic              result_ready,
  output logic              done
);
  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(SETTLE + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ,
    S_TRIAL,
    S_RESULT,
    S_FINISH
  } state_t;

  state_t            r_state;
  logic [NUM_CH-1:0] r_mask;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_dac;
  logic [CH_W-1:0]   r_sel;
  logic              r_busy;
  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [CH_W-1:0]   r_rch;
  logic              r_done;

  logic [WIDTH-1:0]  w_bit;
  logic [WIDTH-1:0]  w_trial_acc;
  logic              w_trial_end;
  logic              w_acq_end;

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int unsigned j = NUM_CH; j > 0; j--) begin
      if (m[CH_W'(j - 1)]) idx = CH_W'(j - 1);
    end
    return idx;
  endfunction

  always_comb begin
    w_bit       = WIDTH'(1) << r_bit;
    w_trial_acc = cmp_in ? (r_acc | w_bit) : r_acc;
    w_trial_end = (r_cnt == CNT_W'(SETTLE));
    w_acq_end   = (r_cnt == CNT_W'(SETTLE - 1));
  end

  // r_mask holds only the channels still pending; each served channel is cleared
  // from it, so the next channel is simply its lowest set bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_acc   <= '0;
      r_dac   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_rch   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (ch_mask != '0) begin
              r_sel   <= lowest_ch(ch_mask);
              r_mask  <= ch_mask & (ch_mask - NUM_CH'(1));
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_dac   <= '0;
              r_state <= S_ACQ;
            end else begin
              r_mask  <= '0;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end
          end
        end
        S_ACQ: begin
          if (w_acq_end) begin
            r_cnt   <= '0;
            r_bit   <= BIT_W'(WIDTH - 1);
            r_acc   <= '0;
            r_dac   <= WIDTH'(1) << (WIDTH - 1);
            r_state <= S_TRIAL;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_TRIAL: begin
          if (w_trial_end) begin
            r_cnt <= '0;
            if (r_bit == '0) begin
              r_data  <= w_trial_acc;
              r_rch   <= r_sel;
              r_valid <= 1'b1;
              r_dac   <= '0;
              r_state <= S_RESULT;
            end else begin
              r_acc <= w_trial_acc;
              r_bit <= r_bit - BIT_W'(1);
              r_dac <= w_trial_acc | (w_bit >> 1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESULT: begin
          if (result_ready) begin
            r_valid <= 1'b0;
            if (r_mask != '0) begin
              r_sel   <= lowest_ch(r_mask);
              r_mask  <= r_mask & (r_mask - NUM_CH'(1));
              r_cnt   <= '0;
              r_state <= S_ACQ;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dac_code     = r_dac;
  assign ch_sel       = r_sel;
  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign result_data  = r_data;
  assign result_ch    = r_rch;
  assign done         = r_done;

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Bench for sar_adc_sequencer: a registered comparator model against per-channel
// analog levels; each result must equal that channel's level, in ascending channel order.
module tb_sar_adc_sequencer;
  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int SETTLE = 2;
  localparam int LAT    = 1 + SETTLE + WIDTH * (SETTLE + 1);

  logic             clk;
  logic             reset;
  logic             start;
  logic [3:0]       ch_mask;
  logic             cmp_in;
  logic [WIDTH-1:0] dac_code;
  logic [CH_W-1:0]  ch_sel;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result_data;
  logic [CH_W-1:0]  result_ch;
  logic             result_ready;
  logic             done;

  sar_adc_sequencer #(
    .WIDTH (WIDTH),
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W),
    .SETTLE(SETTLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ch_mask     (ch_mask),
    .cmp_in      (cmp_in),
    .dac_code    (dac_code),
    .ch_sel      (ch_sel),
    .busy        (busy),
    .result_valid(result_valid),
    .result_data (result_data),
    .result_ch   (result_ch),
    .result_ready(result_ready),
    .done        (done)
  );

  logic [7:0] vin [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cmp_in = 1'b0;
  always @(posedge clk) cmp_in <= (vin[ch_sel] >= dac_code);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  logic [1:0] q_ch[$];
  logic [7:0] q_data[$];

  typedef struct {
    logic [3:0]      mask;
    logic [3:0][7:0] vin;
    int              hold;
    bit              pulse;
    int              n;
    logic [3:0][7:0] exp_data;
    logic [3:0][1:0] exp_ch;
  } vec_t;

  vec_t vecs[6];

  task automatic run_scan(input logic [3:0] m, input int hold, input bit pulse);
    int n_exp, got, wait_cnt, next_valid, last_xfer;
    bit fin;
    n_exp = q_data.size();
    got = 0; wait_cnt = 0; last_xfer = 0; fin = 0;
    next_valid = LAT;
    @(negedge clk);
    ch_mask = m; start = 1'b1; result_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ch_mask = 4'($urandom);
    for (int t = 1; t <= 400 && !fin; t++) begin
      if (t > 1) @(negedge clk);
      start = (pulse && n_exp > 0 && t >= 2 && t <= 20 && $urandom_range(0, 1) == 1);
      chk("busy", int'(busy), int'(got < n_exp));
      if (got < n_exp && busy) chk("ch_sel", int'(ch_sel), int'(q_ch[got]));
      if (got < n_exp && t == next_valid && !result_valid) chk("valid_missing", 0, 1);
      if (result_valid) begin
        if (got >= n_exp) begin
          chk("extra_result", 1, 0);
          result_ready = 1'b1;
        end else begin
          if (wait_cnt == 0) chk("valid_latency", t, next_valid);
          chk("result_data", int'(result_data), int'(q_data[got]));
          chk("result_ch", int'(result_ch), int'(q_ch[got]));
          chk("dac_in_result", int'(dac_code), 0);
          if (wait_cnt < hold) begin
            result_ready = 1'b0;
            wait_cnt++;
          end else begin
            result_ready = 1'b1;
            got++;
            wait_cnt = 0;
            last_xfer = t;
            next_valid = t + LAT;
          end
        end
      end else begin
        result_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        chk("done_time", t, last_xfer + 1);
        chk("busy_with_done", int'(busy), 0);
        fin = 1;
      end
    end
    start = 1'b0;
    if (!fin) chk("scan_timeout", 0, 1);
    chk("result_count", got, n_exp);
    result_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    q_ch.delete();
    q_data.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dac"}, int'(dac_code), 0);
    chk({tag, "_ch_sel"}, int'(ch_sel), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(result_valid), 0);
    chk({tag, "_data"}, int'(result_data), 0);
    chk({tag, "_rch"}, int'(result_ch), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    logic [3:0] m;
    vecs[0] = '{4'b0001, 32'h000000A5, 0,  1'b0, 1, 32'h000000A5, 8'h00};
    vecs[1] = '{4'b0011, 32'h0000FF00, 0,  1'b0, 2, 32'h0000FF00, 8'h04};
    vecs[2] = '{4'b1010, 32'h81003C00, 10, 1'b0, 2, 32'h0000813C, 8'h0D};
    vecs[3] = '{4'b0000, 32'hDEADBEEF, 0,  1'b1, 0, 32'h00000000, 8'h00};
    vecs[4] = '{4'b1111, 32'h78563412, 0,  1'b1, 4, 32'h78563412, 8'hE4};
    vecs[5] = '{4'b1000, 32'h7F000000, 3,  1'b0, 1, 32'h0000007F, 8'h03};

    reset = 1'b1; start = 1'b0; ch_mask = '0; result_ready = 1'b1;
    for (int i = 0; i < 4; i++) vin[i] = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) vin[i] = vecs[v].vin[i];
      for (int j = 0; j < vecs[v].n; j++) begin
        q_data.push_back(vecs[v].exp_data[j]);
        q_ch.push_back(vecs[v].exp_ch[j]);
      end
      run_scan(vecs[v].mask, vecs[v].hold, vecs[v].pulse);
    end

    // Abandon a full scan partway through a conversion.
    for (int i = 0; i < 4; i++) vin[i] = 8'($urandom);
    @(negedge clk);
    ch_mask = 4'hF; start = 1'b1; result_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || result_valid || busy) chk("after_abandon_quiet", 1, 0);
    end
    chk("after_abandon_idle_busy", int'(busy), 0);
    vin[0] = 8'($urandom);
    q_data.push_back(vin[0]);
    q_ch.push_back(2'd0);
    run_scan(4'b0001, 0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      m = 4'($urandom);
      for (int i = 0; i < 4; i++) vin[i] = 8'($urandom);
      for (int c = 0; c < 4; c++) begin
        if (m[c]) begin
          q_data.push_back(vin[c]);
          q_ch.push_back(2'(c));
        end
      end
      run_scan(m, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sar_adc_sequencer.md
Name: sar_adc_sequencer

Overview:
Successive-approximation controller that sequences the shared 1-bit comparator and the reference DAC into multi-bit conversions. It scans a programmable set of analog channels in ascending order. For each channel it selects the input mux, waits for acquisition, runs WIDTH binary-search trials, and delivers one result per channel over a valid/ready interface. It sits between the comparator front end and the sample-processing logic.

Parameters:
WIDTH, 8, conversion resolution in bits (2..16)
NUM_CH, 4, number of muxed analog channels (1..16)
CH_W, 2, channel index width, equal to max(1, clog2(NUM_CH))
SETTLE, 2, DAC/mux settle cycles (>=1; covers the comparator's 1-cycle registered output)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  scan request, sampled only in IDLE
ch_mask  in  NUM_CH  channels to convert; latched on accepted start
cmp_in  in  1  comparator decision, registered; 1 = input >= dac_code
dac_code  out  WIDTH  DAC trial code
ch_sel  out  CH_W  analog mux select
busy  out  1  high from the cycle after an accepted start until scan end
result_valid  out  1  result available
result_data  out  WIDTH  converted code
result_ch  out  CH_W  channel of result_data
result_ready  in  1  consumer accepts the result
done  out  1  one-cycle pulse at scan end

Behaviour:
- Reset values: dac_code=0, ch_sel=0, busy=0, result_valid=0, result_data=0, result_ch=0, done=0. State=IDLE, latched mask=0.
- Reset is synchronous and wins over all other inputs in every state. Reset mid-conversion abandons the scan. No result and no done are produced for the abandoned scan.
- States: IDLE, ACQ, TRIAL, RESULT, FINISH.
- IDLE: start=1 latches ch_mask.
  - If the latched mask is nonzero, go to ACQ, with busy=1 and ch_sel = lowest set channel.
  - If the mask is zero, go to FINISH. busy stays 0 and no results are produced.
- start is ignored in every state except IDLE.
- ACQ: lasts SETTLE cycles, with dac_code=0. Then go to TRIAL with bit index = WIDTH-1 and acc=0.
- TRIAL, per bit i:
  - dac_code = acc | (1<<i), held for SETTLE+1 cycles.
  - cmp_in is sampled in the last of those cycles. If 1, set bit i in acc; if 0, leave it clear.
  - i=0 decided: go to RESULT. Otherwise i decrements and the next trial begins.
- RESULT: result_valid=1, result_data=acc, result_ch=ch_sel, all held stable while result_ready=0. dac_code=0.
- Transfer happens on result_valid & result_ready. Next cycle:
  - If a higher set mask bit remains, go to ACQ on that channel.
  - Otherwise go to FINISH.
- FINISH: lasts 1 cycle, with done=1, busy=0, result_valid=0. Then return to IDLE.
  - start asserted during FINISH is ignored.
  - start in the following IDLE cycle is accepted.
- Latency: start accepted at edge k gives first result_valid=1 in cycle k+1+SETTLE+WIDTH*(SETTLE+1). With defaults this is k+27.
- Each additional channel adds SETTLE+WIDTH*(SETTLE+1)+1 cycles when result_ready is held at 1. With defaults this is 27.
- Mask changes after acceptance have no effect. Non-contiguous masks skip unset channels with no extra cycles.
- Arithmetic: acc is WIDTH bits, with no overflow possible. Codes 0 and 2^WIDTH-1 are reachable.

Test Plan:
- Bench model: cmp_in = registered (vin[ch_sel] >= dac_code).
- Single channel: mask=0001, vin0=0xA5, ready=1, start at edge k -> result_valid in cycle k+27, data=0xA5, ch=0. done pulses the cycle after transfer; busy=0 with done.
- Extremes: mask=0011, vin0=0x00, vin1=0xFF -> results (ch0, 0x00) then (ch1, 0xFF). The second valid is 27 cycles after the first transfer.
- Backpressure plus sparse mask: mask=1010, vin1=0x3C, vin3=0x81, ready held low 10 cycles -> (ch1, 0x3C) stable all 10 cycles, then (ch3, 0x81). Channels 0 and 2 are never selected.
- Empty mask and ignored start: start with mask=0000 -> done in the next cycle, busy never 1, no results. start pulses while busy -> no effect on the result sequence.
- Reset mid-scan: mask=1111, reset asserted in cycle k+15 -> all outputs at reset values the next cycle, no done. A new start converts vin0 correctly.
